// File: rtl/alu_iterative_exec.sv
// alu_iterative_exec: handshaked execute ALU with single-cycle logic/arith and a bit-serial shifter
module alu_iterative_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alu_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               carry,
  output logic               overflow,
  output logic               sign
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state;
  logic [WIDTH-1:0]   acc, bx, alu_r, shifted;
  logic [WIDTH:0]     sum;
  logic [SHAMT_W-1:0] cnt, shamt;
  logic [1:0]         kind;
  logic               is_add, is_sub, is_arith, is_shift, ovf, slt, sltu;
  always_comb begin
    is_add   = alu_sel == 4'b0000 || alu_sel == 4'b0010;
    is_sub   = alu_sel == 4'b0001 || alu_sel == 4'b0110;
    is_arith = is_add || is_sub;
    is_shift = alu_sel == 4'b1000 || alu_sel == 4'b1001 || alu_sel == 4'b1010;
    shamt    = b[SHAMT_W-1:0];
    bx       = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    ovf      = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    slt      = $signed(a) < $signed(b);
    sltu     = a < b;
    alu_r    = is_arith              ? sum[WIDTH-1:0] :
               alu_sel == 4'b0100    ? a | b :
               alu_sel == 4'b0101    ? a & b :
               alu_sel == 4'b0111    ? a ^ b :
               is_shift              ? a :
               alu_sel == 4'b1101    ? {{(WIDTH-1){1'b0}}, slt} :
               alu_sel == 4'b1111    ? {{(WIDTH-1){1'b0}}, sltu} : '0;
    // kind holds alu_sel[1:0]: 00 SLL, 01 SRL, 10 SRA
    shifted  = kind == 2'b00 ? {acc[WIDTH-2:0], 1'b0} :
               kind == 2'b01 ? {1'b0, acc[WIDTH-1:1]} :
                               {acc[WIDTH-1], acc[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      sign      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      kind      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          kind     <= alu_sel[1:0];
          if (is_shift && shamt != '0) begin
            acc   <= a;
            cnt   <= shamt;
            state <= SHIFT;
          end else begin
            result    <= alu_r;
            zero      <= alu_r == '0;
            sign      <= alu_r[WIDTH-1];
            carry     <= is_arith & sum[WIDTH];
            overflow  <= is_arith & ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        SHIFT: begin
          acc <= shifted;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result    <= shifted;
            zero      <= shifted == '0;
            sign      <= shifted[WIDTH-1];
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iterative_exec.sv
// tb_alu_iterative_exec: directed and random ops against an arithmetic reference model
module tb_alu_iterative_exec;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        zero, carry, overflow, sign;
  logic [31:0] a, b, result;
  logic [3:0]  alu_sel;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_iterative_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .sign(sign)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [31:0] x, y, input logic [3:0] s,
                       output logic [31:0] r, output logic c, v, output int lat);
    int     sh;
    longint t;
    sh = int'(y[4:0]);
    r = '0; c = 1'b0; v = 1'b0; lat = 1;
    case (s)
      4'd0, 4'd2: begin
        r = x + y;
        c = (longint'(x) + longint'(y)) > longint'(32'hFFFF_FFFF);
        t = longint'($signed(x)) + longint'($signed(y));
        v = t != longint'($signed(r));
      end
      4'd1, 4'd6: begin
        r = x - y;
        c = x >= y;
        t = longint'($signed(x)) - longint'($signed(y));
        v = t != longint'($signed(r));
      end
      4'd4: r = x | y;
      4'd5: r = x & y;
      4'd7: r = x ^ y;
      4'd8: begin r = x << sh; lat = sh + 1; end
      4'd9: begin r = x >> sh; lat = sh + 1; end
      4'd10: begin r = $signed(x) >>> sh; lat = sh + 1; end
      4'd13: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd15: r = (x < y) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
  endtask
  task automatic op(input logic [31:0] x, y, input logic [3:0] s, input int hold);
    logic [31:0] er;
    logic        ec, ev;
    int          el, lat;
    model(x, y, s, er, ec, ev, el);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = x; b = y; alu_sel = s; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat <= 40) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom; alu_sel = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("result", result, er);
    chk("zero", 32'(zero), 32'(er == 32'd0));
    chk("sign", 32'(sign), 32'(er[31]));
    chk("carry", 32'(carry), 32'(ec));
    chk("overflow", 32'(overflow), 32'(ev));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom; alu_sel = 4'($urandom);
      @(negedge clk);
      chk("hold_result", result, er);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("handoff_valid", 32'(out_valid), 32'd0);
    chk("handoff_ready", 32'(in_ready), 32'd1);
  endtask
  initial begin
    logic [3:0] codes [12];
    int         seen;
    codes = '{4'd0, 4'd2, 4'd1, 4'd6, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13, 4'd15};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, zero, carry, overflow, sign}, 32'd0);
    rst = 1'b0;
    op(32'h7FFF_FFFF, 32'd1, 4'b0000, 0);
    op(32'd5, 32'd5, 4'b0110, 0);
    op(32'd3, 32'd5, 4'b0001, 0);
    op(32'd1, 32'd31, 4'b1000, 0);
    op(32'd1, 32'h20, 4'b1000, 0);
    op(32'h8000_0000, 32'd4, 4'b1010, 0);
    op(32'h8000_0000, 32'd4, 4'b1001, 0);
    op(32'h8000_0000, 32'd31, 4'b1010, 0);
    op(32'hFFFF_FFFF, 32'd1, 4'b1101, 0);
    op(32'hFFFF_FFFF, 32'd1, 4'b1111, 0);
    op(32'h8000_0000, 32'h8000_0000, 4'b0010, 0);
    op($urandom, $urandom, 4'b0111, 10);
    @(negedge clk);
    a = 32'd1; b = 32'd20; alu_sel = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    chk("abort_discarded", 32'(seen), 32'd0);
    op(32'd2, 32'd3, 4'b0000, 0);
    op(32'hDEAD_BEEF, 32'h1234_5678, 4'b0011, 0);
    for (int n = 0; n < 150; n++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 11)];
      op($urandom, $urandom, s, $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
